// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-256 encryption core.
//   - NR / BLOCK_W / ROUND_KEY_BUS_W : round count and bus widths
//   - state_t                        : core FSM encoding
//   - key_slice()                    : 128-bit round-key mux out of the flat key bus
//   - add_round_key / sub_bytes / shift_rows : AES round primitives
// Byte ordering everywhere: byte 0 of a block lives in bits [127:120], and
// the AES state is column-major (byte n = row n%4, column n/4).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR              = 14;
    localparam int BLOCK_W         = 128;
    localparam int ROUND_KEY_BUS_W = BLOCK_W * (NR + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [BLOCK_W-1:0] block_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[8*(255 - int'(b)) +: 8];
    endfunction

    // Explicit compare-and-select mux; an out-of-range index yields zero
    // instead of an out-of-bounds part-select.
    function automatic block_t key_slice(input logic [ROUND_KEY_BUS_W-1:0] bus,
                                         input logic [3:0]                 idx);
        block_t k;
        k = '0;
        for (int i = 0; i <= NR; i++) begin
            if (idx == 4'(i)) begin
                k = bus[BLOCK_W*i +: BLOCK_W];
            end
        end
        return k;
    endfunction

    function automatic block_t add_round_key(input block_t b, input block_t k);
        return b ^ k;
    endfunction

    function automatic block_t sub_bytes(input block_t b);
        block_t r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(b[8*i +: 8]);
        end
        return r;
    endfunction

    // Row r is rotated left by r columns: out[r,c] = in[r,(c+r)%4].
    function automatic block_t shift_rows(input block_t b);
        block_t r;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1-8*(row+4*col) -: 8] =
                    b[BLOCK_W-1-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_last_round.sv
// ---------------------------------------------------------------------------
// aes_enc_last_round
// Combinational final AES round including the closing whitening key:
//   res = ShiftRows(SubBytes(data ^ rkey_first)) ^ rkey_last
// Ports:
//   data        in  128  state after the last full round
//   rkey_first  in  128  round key 13
//   rkey_last   in  128  round key 14
//   res         out 128  ciphertext
// ---------------------------------------------------------------------------
module aes_enc_last_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    input  logic [BLOCK_W-1:0] rkey_first,
    input  logic [BLOCK_W-1:0] rkey_last,
    output logic [BLOCK_W-1:0] res
);

    assign res = add_round_key(shift_rows(sub_bytes(add_round_key(data, rkey_first))),
                               rkey_last);

endmodule

// File: rtl/aes_enc_round_fun.sv
// ---------------------------------------------------------------------------
// aes_enc_round_fun
// Combinational AES full round in the core's order:
//   res = MixColumns(ShiftRows(SubBytes(data ^ rkey)))
// Ports:
//   data  in  128  current round state
//   rkey  in  128  round key applied before the substitution
//   res   out 128  next round state
// ---------------------------------------------------------------------------
module aes_enc_round_fun
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    input  logic [BLOCK_W-1:0] rkey,
    output logic [BLOCK_W-1:0] res
);

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column times the fixed matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    block_t shifted;

    assign shifted = shift_rows(sub_bytes(add_round_key(data, rkey)));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            assign res[BLOCK_W-1-32*gi -: 32] = mix_column(shifted[BLOCK_W-1-32*gi -: 32]);
        end
    endgenerate

endmodule

// File: rtl/aes_enc_iter_core.sv
// ---------------------------------------------------------------------------
// aes_enc_iter_core
// Iterative AES-256 encryption engine, one round per clock.
//   IDLE : waits for a block (outReady=1).
//   RUN  : rnd 0..12 apply a full round with key rnd; rnd 13 applies the last
//          round with keys 13 and 14 and loads outData.
//   DONE : presents outData with outValid=1 until inReady.
// A block accepted at edge T is valid after edge T+14; with inReady held
// high the next accept lands on edge T+16 (IDLE, 14x RUN, DONE).
// Ports:
//   inClk     in   1          clock, rising edge
//   inRst     in   1          asynchronous active-high reset
//   inData    in   128        plaintext block
//   inValid   in   1          plaintext valid
//   outReady  out  1          core can accept a block
//   inKeys    in   KEY_BUS_W  pre-expanded round keys, key i at [128*i +: 128]
//   outData   out  128        ciphertext block
//   outValid  out  1          ciphertext valid
//   inReady   in   1          downstream can take outData
//   outBusy   out  1          high while RUN or DONE
// inKeys is not captured; it must stay stable from accept until DONE.
// ---------------------------------------------------------------------------
module aes_enc_iter_core #(
    parameter int NR        = 14,
    parameter int KEY_BUS_W = 128 * (NR + 1)
) (
    input  logic                          inClk,
    input  logic                          inRst,
    input  logic [aes_pkg::BLOCK_W-1:0]   inData,
    input  logic                          inValid,
    output logic                          outReady,
    input  logic [KEY_BUS_W-1:0]          inKeys,
    output logic [aes_pkg::BLOCK_W-1:0]   outData,
    output logic                          outValid,
    input  logic                          inReady,
    output logic                          outBusy
);

    import aes_pkg::*;

    generate
        if (NR != 14 || KEY_BUS_W != ROUND_KEY_BUS_W) begin : g_bad_cfg
            $error("aes_enc_iter_core: only NR=14 with KEY_BUS_W=1920 is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_FULL_RND = 4'(NR - 2);
    localparam logic [3:0] LAST_RND      = 4'(NR - 1);
    localparam logic [3:0] FINAL_KEY     = 4'(NR);

    state_t     state_reg, state_next;
    logic [3:0] rnd_reg, rnd_next;
    block_t     blk_reg, blk_next;
    block_t     out_data_reg, out_data_next;

    block_t     round_key;
    block_t     key_first_last;
    block_t     key_final;
    block_t     round_res;
    block_t     last_res;

    // Only the full-round key is muxed; the last-round keys are fixed slices.
    assign round_key      = key_slice(inKeys, rnd_reg);
    assign key_first_last = key_slice(inKeys, LAST_RND);
    assign key_final      = key_slice(inKeys, FINAL_KEY);

    aes_enc_round_fun u_round (
        .data (blk_reg),
        .rkey (round_key),
        .res  (round_res)
    );

    aes_enc_last_round u_last (
        .data       (blk_reg),
        .rkey_first (key_first_last),
        .rkey_last  (key_final),
        .res        (last_res)
    );

    // Ready is masked while reset is held so nothing looks acceptable
    // before the core is actually running.
    assign outReady = (state_reg == IDLE) && !inRst;
    assign outValid = (state_reg == DONE);
    assign outBusy  = (state_reg != IDLE);
    assign outData  = out_data_reg;

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state_reg    <= IDLE;
            rnd_reg      <= '0;
            blk_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rnd_reg      <= rnd_next;
            blk_reg      <= blk_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rnd_next      = rnd_reg;
        blk_next      = blk_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (inValid && outReady) begin
                    blk_next   = inData;
                    rnd_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rnd_reg <= LAST_FULL_RND) begin
                    blk_next = round_res;
                    rnd_next = rnd_reg + 4'd1;
                end else if (rnd_reg == LAST_RND) begin
                    out_data_next = last_res;
                    state_next    = DONE;
                end else begin
                    // Counter values past the last round cannot occur; recover.
                    state_next = IDLE;
                    rnd_next   = '0;
                end
            end
            DONE: begin
                if (inReady) begin
                    state_next = IDLE;
                    rnd_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                rnd_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_iter_core
// Self-checking bench for aes_enc_iter_core. The reference model derives its
// own S-box from the GF(2^8) inverse and affine map, expands AES-256 keys and
// encrypts in the textbook round order.
// ---------------------------------------------------------------------------
module tb_aes_enc_iter_core;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   in_data;
    logic           in_valid;
    logic           out_ready;
    logic [1919:0]  in_keys;
    logic [127:0]   out_data;
    logic           out_valid;
    logic           in_ready;
    logic           out_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tsbox [256];

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    aes_enc_iter_core #(.NR(14), .KEY_BUS_W(1920)) dut (
        .inClk    (clk),
        .inRst    (rst),
        .inData   (in_data),
        .inValid  (in_valid),
        .outReady (out_ready),
        .inKeys   (in_keys),
        .outData  (out_data),
        .outValid (out_valid),
        .inReady  (in_ready),
        .outBusy  (out_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, r, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ 8'h63;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            tsbox[a] = s;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tsbox[w[31:24]], tsbox[w[23:16]], tsbox[w[15:8]], tsbox[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] bus;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) bus[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return bus;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1919:0] ks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, ct;
        rk = ks[127:0];
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[127-8*n -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int n = 0; n < 16; n++) t[n] = tsbox[s[n]];
            for (int n = 0; n < 16; n++) s[n] = t[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            rk = ks[128*r +: 128];
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
        return ct;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock: sample 1 time unit after the edge and police the output
    // handshake (held while stalled, dropped after a taken transfer).
    task automatic tick();
        logic         pv, pr;
        logic [127:0] pd;
        pv = out_valid;
        pr = in_ready;
        pd = out_data;
        @(posedge clk);
        #1;
        if (pv && !pr) check("hold_during_stall", {out_valid, out_data}, {1'b1, pd});
        if (pv && pr)  check("valid_drop_after_handshake", out_valid, 1'b0);
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [1919:0] ks,
                             input logic [127:0] exp_ct, input int max_stall);
        int           lat, stall;
        logic [127:0] ct;
        in_keys  = ks;
        in_data  = pt;
        in_valid = 1'b1;
        check({name, " ready_before_accept"}, out_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (max_stall > 0) in_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'd14);
        ct = out_data;
        check({name, " ciphertext"}, ct, exp_ct);
        stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        for (int i = 0; i < stall; i++) begin
            in_ready = 1'b0;
            tick();
        end
        in_ready = 1'b1;
        tick();
        check({name, " release_valid_ready_busy"}, {out_valid, out_ready, out_busy}, 3'b010);
        $display("[TB] %s pt=%h ct=%h latency=%0d stall=%0d", name, pt, ct, lat, stall);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t          vecs [4];
        logic [1919:0] ks, ks_c3;
        logic [127:0]  b2b_pt [4];
        logic [127:0]  b2b_ct [4];
        logic          ok, acc, hs;
        int            acc_n, res_n, last_acc;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        in_data  = '0;
        in_keys  = '0;
        build_sbox();

        vecs[0] = '{C3_KEY, C3_PT, C3_CT};
        vecs[1] = '{256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087};
        vecs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};
        vecs[3] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h591ccb10d410ed26dc5ba74a31362870};
        ks_c3 = expand_key(C3_KEY);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_busy", {out_valid, out_busy}, 2'b00);
        check("reset_out_data", out_data, 128'h0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", out_ready, 1'b1);

        // Known-answer vectors
        for (int i = 0; i < 4; i++) begin
            ks = expand_key(vecs[i].key);
            check($sformatf("model_kat%0d", i), model_encrypt(vecs[i].pt, ks), vecs[i].ct);
            run_block($sformatf("kat%0d", i), vecs[i].pt, ks, vecs[i].ct, 0);
        end

        // Backpressure: 20 stalled cycles in DONE with stray inValid pulses
        in_ready = 1'b0;
        in_keys  = ks_c3;
        in_data  = C3_PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            check("bp_latency", 128'(n), 128'd14);
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
            tick();
            if (!(out_valid === 1'b1 && out_data === C3_CT && out_ready === 1'b0 && out_busy === 1'b1))
                ok = 1'b0;
        end
        check("bp_stable_20_cycles", ok, 1'b1);
        check("bp_data", out_data, C3_CT);
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        check("bp_release_valid_ready", {out_valid, out_ready}, 2'b01);
        tick();
        check("bp_no_stray_accept", out_busy, 1'b0);
        $display("[TB] backpressure ct=%h", C3_CT);

        // Back-to-back: inValid and inReady held high
        ks = expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            b2b_pt[i] = rand128();
            b2b_ct[i] = model_encrypt(b2b_pt[i], ks);
        end
        in_keys  = ks;
        in_ready = 1'b1;
        in_data  = b2b_pt[0];
        in_valid = 1'b1;
        acc_n    = 0;
        res_n    = 0;
        last_acc = 0;
        for (int c = 0; c < 120 && res_n < 4; c++) begin
            acc = in_valid && out_ready;
            hs  = out_valid && in_ready;
            if (hs) begin
                check($sformatf("b2b_ct%0d", res_n), out_data, b2b_ct[res_n]);
                $display("[TB] b2b%0d pt=%h ct=%h", res_n, b2b_pt[res_n], out_data);
                res_n++;
            end
            tick();
            if (acc) begin
                if (acc_n > 0) check($sformatf("b2b_spacing%0d", acc_n), 128'(c - last_acc), 128'd16);
                last_acc = c;
                acc_n++;
                if (acc_n < 4) in_data = b2b_pt[acc_n];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_results_seen", 128'(res_n), 128'd4);

        // Asynchronous reset in the middle of round 7
        in_keys  = ks_c3;
        in_data  = C3_PT;
        in_valid = 1'b1;
        in_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid_busy", {out_valid, out_busy}, 2'b00);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_ready", out_ready, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0 || out_busy !== 1'b0) ok = 1'b0;
        end
        check("async_rst_no_partial_output", ok, 1'b1);
        $display("[TB] async reset at round 7 applied");
        run_block("c3_after_reset", C3_PT, ks_c3, C3_CT, 0);

        // Random regression with downstream stalls
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] pt;
            ks = expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            pt = rand128();
            run_block($sformatf("rand%0d", i), pt, ks, model_encrypt(pt, ks), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
